timebase_scheduler: RTL and testbench

//  Shared timebase controller. One prescaler divides clk down to a base tick. NCH

---
 rtl/timebase_pkg.sv | 14 +
 rtl/timer_channel.sv | 92 +++++++++
 rtl/timebase_scheduler.sv | 78 +++++++
 tb/tb_timebase_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared types and helpers for the timebase scheduler and its timer channels.
package timebase_pkg;

  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_t;
  typedef enum logic {MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1} ch_mode_t;

  // Clocks per base tick; returns 0 for a nonsensical tick rate so the
  // elaboration check in the top level trips.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 0;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM counting shared base ticks, with a
// period/mode config register, a 1-cycle expiry pulse and a toggling square output.
module timer_channel
  import timebase_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_period,
  input  logic          cfg_mode,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          pulse,
  output logic          sq
);

  ch_state_t     state_reg, state_next;
  ch_mode_t      mode_reg, mode_next;
  logic [PW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] period_reg, period_next;
  logic          pulse_reg, pulse_next;
  logic          sq_reg, sq_next;

  // State and output registers; active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= CH_IDLE;
      mode_reg   <= MODE_ONESHOT;
      cnt_reg    <= '0;
      period_reg <= PW'(1);
      pulse_reg  <= 1'b0;
      sq_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      pulse_reg  <= pulse_next;
      sq_reg     <= sq_next;
    end
  end

  // Next state: stop beats expiry beats start. A start samples the period
  // and mode held before any config written in the same cycle.
  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    cnt_next    = cnt_reg;
    period_next = period_reg;
    pulse_next  = 1'b0;
    sq_next     = sq_reg;

    if (cfg_we) begin
      period_next = (cfg_period == '0) ? PW'(1) : cfg_period;
      mode_next   = ch_mode_t'(cfg_mode);
    end

    case (state_reg)
      CH_IDLE: begin
        if (start && !stop) begin
          state_next = CH_RUN;
          cnt_next   = period_reg;
          sq_next    = 1'b0;
        end
      end
      CH_RUN: begin
        if (stop) begin
          state_next = CH_IDLE;
        end else if (tick) begin
          if (cnt_reg > PW'(1)) begin
            cnt_next = cnt_reg - PW'(1);
          end else begin
            pulse_next = 1'b1;
            sq_next    = ~sq_reg;
            if (mode_reg == MODE_PERIODIC) cnt_next = period_reg;
            else                           state_next = CH_IDLE;
          end
        end
      end
      default: state_next = CH_IDLE;
    endcase
  end

  assign busy  = (state_reg == CH_RUN);
  assign pulse = pulse_reg;
  assign sq    = sq_reg;

endmodule

// File: rtl/timebase_scheduler.sv
// Shared timebase: one prescaler producing base_tick, plus NCH timer channels
// configured through a single valid/ready port and started/stopped per channel.
module timebase_scheduler
  import timebase_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1_000,
  parameter int NCH     = 4,
  parameter int PW      = 16,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  input  logic           cfg_mode,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] pulse,
  output logic [NCH-1:0] sq,
  output logic           base_tick
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;

  // Reject clock/tick ratios that are fractional or too small to divide.
  generate
    if (DIV < 2 || DIV * TICK_HZ != CLK_HZ || NCH < 1) begin : g_param_check
      $error("timebase_scheduler: CLK_HZ/TICK_HZ must be an integer >= 2 and NCH >= 1");
    end
  endgenerate

  logic [PSW-1:0] presc_reg;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] cfg_we;

  // Prescaler counts 0..DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (!rst)                            presc_reg <= '0;
    else if (presc_reg == PSW'(DIV - 1)) presc_reg <= '0;
    else                                 presc_reg <= presc_reg + PSW'(1);
  end

  assign base_tick = (presc_reg == PSW'(DIV - 1));

  // A running target channel stalls configuration.
  assign cfg_ready = ~|(hit & busy);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      if (NCH == 1) begin : g_single
        assign hit[gi] = 1'b1;
      end else begin : g_multi
        assign hit[gi] = (cfg_ch == CHW'(gi));
      end
      assign cfg_we[gi] = cfg_valid && hit[gi] && !busy[gi];

      timer_channel #(.PW(PW)) u_ch (
        .clk        (clk),
        .rst        (rst),
        .tick       (base_tick),
        .cfg_we     (cfg_we[gi]),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start[gi]),
        .stop       (stop[gi]),
        .busy       (busy[gi]),
        .pulse      (pulse[gi]),
        .sq         (sq[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_timebase_scheduler.sv
// Scoreboard bench for timebase_scheduler: the driver advances a tick-counting
// reference model each clock and queues the expected outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_timebase_scheduler;

  localparam int NCH = 4;
  localparam int PW  = 8;
  localparam int DIV = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic           cfg_mode = 1'b0;
  logic [NCH-1:0] start = '0;
  logic [NCH-1:0] stop = '0;
  logic [NCH-1:0] busy, pulse, sq;
  logic           base_tick;

  always #5 clk = ~clk;

  timebase_scheduler #(.CLK_HZ(10), .TICK_HZ(1), .NCH(NCH), .PW(PW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .start(start), .stop(stop), .busy(busy), .pulse(pulse), .sq(sq),
    .base_tick(base_tick)
  );

  typedef struct {
    int             cyc;
    logic [NCH-1:0] busy, pulse, sq;
    logic           tick, ready;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model: edges since reset, remaining ticks per running channel.
  bit m_valid = 0;
  int m_n = 0;
  bit m_run[NCH];
  int m_rem[NCH];
  int m_per[NCH];
  bit m_mode[NCH];
  bit m_sq[NCH];
  bit m_pulse[NCH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic model_update();
    bit tk;
    if (!rst) begin
      m_valid = 1;
      m_n = 0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_rem[c] = 0; m_per[c] = 1; m_mode[c] = 0; m_sq[c] = 0; m_pulse[c] = 0;
      end
      return;
    end
    if (!m_valid) return;
    tk = ((m_n % DIV) == DIV - 1);
    m_n++;
    for (int c = 0; c < NCH; c++) begin
      bit was_run;
      bit acc;
      was_run = m_run[c];
      acc = cfg_valid && (int'(cfg_ch) == c) && !was_run;
      m_pulse[c] = 0;
      if (was_run) begin
        if (stop[c]) m_run[c] = 0;
        else if (tk) begin
          m_rem[c]--;
          if (m_rem[c] == 0) begin
            m_pulse[c] = 1;
            m_sq[c] = !m_sq[c];
            if (m_mode[c]) m_rem[c] = m_per[c];
            else           m_run[c] = 0;
          end
        end
      end else if (start[c] && !stop[c]) begin
        m_run[c] = 1;
        m_rem[c] = m_per[c];
        m_sq[c]  = 0;
      end
      if (acc) begin
        m_per[c]  = (cfg_period == 0) ? 1 : int'(cfg_period);
        m_mode[c] = cfg_mode;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    if (!m_valid) return;
    e.cyc = cyc;
    for (int c = 0; c < NCH; c++) begin
      e.busy[c]  = m_run[c];
      e.pulse[c] = m_pulse[c];
      e.sq[c]    = m_sq[c];
    end
    e.tick  = ((m_n % DIV) == DIV - 1);
    e.ready = !m_run[cfg_ch];
    expq.push_back(e);
  endtask

  // One clock: queue expectation for the current cycle, take the edge, update model.
  task automatic step();
    push_exp();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic wait_pulse(input int c, input int budget, output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!pulse[c] && waited < budget);
    if (!pulse[c]) check($sformatf("pulse%0d_timeout", c), 32'd0, 32'd1);
  endtask

  task automatic do_cfg(input int c, input int p, input bit m);
    cfg_valid = 1; cfg_ch = 2'(c); cfg_period = PW'(p); cfg_mode = m;
    step();
    cfg_valid = 0;
  endtask

  task automatic do_start(input int c);
    start[c] = 1'b1;
    step();
    start = '0;
  endtask

  exp_t mon_e;

  // Monitor: compare every queued expectation against the DUT outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        check("busy",      32'(busy),      32'(mon_e.busy));
        check("pulse",     32'(pulse),     32'(mon_e.pulse));
        check("sq",        32'(sq),        32'(mon_e.sq));
        check("base_tick", 32'(base_tick), 32'(mon_e.tick));
        check("cfg_ready", 32'(cfg_ready), 32'(mon_e.ready));
        if (pulse != '0)
          $display("cyc %0d pulse=%b sq=%b busy=%b", mon_e.cyc, pulse, sq, busy);
      end
    end
  end

  initial begin
    int w, k;
    logic sq_before;

    // 1: reset, then first base_tick 9 cycles after release
    repeat (3) step();
    rst = 1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    k = 0;
    while (!base_tick && k < 20) begin step(); k++; end
    check("first_tick_cycle", k, 9);

    // 2: ch0 period 3 periodic
    do_cfg(0, 3, 1);
    do_start(0);
    check("busy0_after_start", 32'(busy[0]), 32'd1);
    wait_pulse(0, 40, w);
    check("ch0_first_in_range", 32'(w >= 21 && w <= 30), 32'd1);
    wait_pulse(0, 40, w);
    check("ch0_period_gap", w, 30);

    // 3: ch1 period 2 one-shot
    do_cfg(1, 2, 0);
    do_start(1);
    wait_pulse(1, 40, w);
    check("ch1_busy_at_pulse", 32'(busy[1]), 32'd0);
    k = 0;
    repeat (100) begin step(); if (pulse[1]) k++; end
    check("ch1_no_repeat", k, 0);

    // 4: ch2 period 1 periodic, stop on an expiring tick
    do_cfg(2, 1, 1);
    do_start(2);
    wait_pulse(2, 15, w);
    k = 0;
    while (!base_tick && k < 12) begin step(); k++; end
    sq_before = sq[2];
    stop[2] = 1'b1;
    step();
    stop = '0;
    check("ch2_stop_no_pulse", 32'(pulse[2]), 32'd0);
    check("ch2_stop_busy", 32'(busy[2]), 32'd0);
    check("ch2_stop_sq_held", 32'(sq[2]), 32'(sq_before));

    // 5: config of a running channel stalls; period 0 stored as 1
    cfg_valid = 1; cfg_ch = 2'd0; cfg_period = 8'd7; cfg_mode = 0;
    #1;
    check("cfg_ready_running", 32'(cfg_ready), 32'd0);
    repeat (3) step();
    cfg_valid = 0;
    wait_pulse(0, 40, w);
    wait_pulse(0, 40, w);
    check("ch0_period_kept", w, 30);
    cfg_valid = 1; cfg_ch = 2'd3; cfg_period = 8'd0; cfg_mode = 1;
    #1;
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 0;
    do_start(3);
    wait_pulse(3, 15, w);
    check("ch3_first_in_range", 32'(w >= 1 && w <= 10), 32'd1);
    wait_pulse(3, 15, w);
    check("ch3_gap", w, 10);

    // 6: everything running, one-cycle reset aborts all; starts during reset ignored
    do_cfg(1, 4, 1);
    start = 4'b0110;
    step();
    start = '0;
    check("all_busy", 32'(busy), 32'hF);
    rst = 0; start = '1;
    step();
    rst = 1; start = '0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pulse", 32'(pulse), 32'd0);
    check("abort_sq", 32'(sq), 32'd0);
    step();
    check("abort_no_restart", 32'(busy), 32'd0);

    // Random phase
    repeat (2500) begin
      rst        = ($urandom_range(0, 299) != 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_period = PW'($urandom_range(0, 4));
      cfg_mode   = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 7) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
      end
      step();
    end
    rst = 1; cfg_valid = 0; start = '0; stop = '0;
    repeat (3) step();
    @(negedge clk);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
